seq_detector_param: RTL and testbench

Parametrised serial pattern detector. It is the successor to the fixed 4-bit Moore sequence detectors in the FSM library.
- Pattern width is a parameter; the pattern value is runtime-loadable.
- Overlap or non-overlap detection is selected per cycle.
- A saturating match counter and a history fill level are exposed for debug.
- Sits on a 1-bit serial input stream in the same clock domain as its consumer.

---
 rtl/seq_detector_param.sv | 66 ++++++
 tb/tb_seq_detector_param.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with a runtime-loadable pattern,
// per-cycle overlap/non-overlap selection, a saturating match counter and a
// history fill level. All outputs are registered.
module seq_detector_param #(
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(4'b1010),
  parameter int unsigned      CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         in,
  input  logic                         overlap,
  input  logic                         pat_load,
  input  logic [PAT_W-1:0]             pat_in,
  output logic                         out,
  output logic [CNT_W-1:0]             match_cnt,
  output logic [$clog2(PAT_W+1)-1:0]   fill
);

  localparam int unsigned       FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0] pattern;
  // Only the newest PAT_W-1 bits are ever needed to form the next candidate.
  logic [PAT_W-2:0] history;
  logic [PAT_W-1:0] cand;
  logic             hit;

  // Candidate window: stored history with the incoming bit as the newest LSB.
  assign cand = {history, in};
  assign hit  = (fill >= FILL_ARM) && (cand == pattern);

  // Pattern register, history shift, fill tracking, match pulse and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern   <= PATTERN;
      history   <= '0;
      fill      <= '0;
      out       <= 1'b0;
      match_cnt <= '0;
    end else if (pat_load) begin
      pattern   <= pat_in;
      history   <= '0;
      fill      <= '0;
      out       <= 1'b0;
      match_cnt <= '0;
    end else if (en) begin
      history <= cand[PAT_W-2:0];
      out     <= hit;
      if (hit) begin
        if (match_cnt != {CNT_W{1'b1}}) begin
          match_cnt <= match_cnt + CNT_W'(1);
        end
        // Non-overlap demands PAT_W fresh bits; overlap keeps the window armed.
        fill <= overlap ? FILL_MAX : '0;
      end else if (fill != FILL_MAX) begin
        fill <= fill + FILL_W'(1);
      end
    end else begin
      out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed vector table, a CNT_W=2 saturation
// sequence on a second instance, and randomized traffic against a bit-queue
// reference model.
module tb_seq_detector_param;

  localparam int unsigned PAT_W  = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned FILL_W = $clog2(PAT_W + 1);
  localparam logic [PAT_W-1:0] DEF_PAT = 4'b1010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (defaults)
  logic             rst = 1'b1, en = 1'b0, din = 1'b0, ov = 1'b0, ld = 1'b0;
  logic [PAT_W-1:0] pin = '0;
  logic             out;
  logic [CNT_W-1:0] match_cnt;
  logic [FILL_W-1:0] fill;

  seq_detector_param #(.PAT_W(PAT_W), .PATTERN(DEF_PAT), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .en(en), .in(din), .overlap(ov), .pat_load(ld),
    .pat_in(pin), .out(out), .match_cnt(match_cnt), .fill(fill)
  );

  // Saturation instance: all-zero pattern, 2-bit counter
  logic             s_rst = 1'b1, s_en = 1'b0, s_din = 1'b0, s_ov = 1'b0, s_ld = 1'b0;
  logic [PAT_W-1:0] s_pin = '0;
  logic             s_out;
  logic [1:0]       s_cnt;
  logic [FILL_W-1:0] s_fill;

  seq_detector_param #(.PAT_W(PAT_W), .PATTERN(4'b0000), .CNT_W(2)) u_sat (
    .clk(clk), .rst(s_rst), .en(s_en), .in(s_din), .overlap(s_ov), .pat_load(s_ld),
    .pat_in(s_pin), .out(s_out), .match_cnt(s_cnt), .fill(s_fill)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic             rst, en, din, ov, ld;
    logic [PAT_W-1:0] pin;
    logic             e_out;
    int               e_fill;
    int               e_cnt;
    string            tag;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic e, input logic d, input logic o,
                              input logic l, input logic [PAT_W-1:0] p,
                              input logic eo, input int ef, input int ec, input string t);
    vec_t v;
    v.rst = r; v.en = e; v.din = d; v.ov = o; v.ld = l; v.pin = p;
    v.e_out = eo; v.e_fill = ef; v.e_cnt = ec; v.tag = t;
    return v;
  endfunction

  // Apply one set of inputs to the main instance across one rising edge.
  task automatic apply(input logic r, input logic e, input logic d, input logic o,
                       input logic l, input logic [PAT_W-1:0] p);
    rst = r; en = e; din = d; ov = o; ld = l; pin = p;
    @(posedge clk);
    #1;
  endtask

  // Reference model: queue of fresh bits (oldest first), capped at PAT_W.
  int               m_q[$];
  logic [PAT_W-1:0] m_pat;
  int               m_cnt;
  logic             m_out;

  task automatic model_step(input logic r, input logic e, input logic d, input logic o,
                            input logic l, input logic [PAT_W-1:0] p);
    int v;
    if (r) begin
      m_pat = DEF_PAT; m_q.delete(); m_cnt = 0; m_out = 1'b0;
    end else if (l) begin
      m_pat = p; m_q.delete(); m_cnt = 0; m_out = 1'b0;
    end else if (!e) begin
      m_out = 1'b0;
    end else begin
      m_q.push_back(int'(d));
      if (m_q.size() > int'(PAT_W)) void'(m_q.pop_front());
      v = 0;
      foreach (m_q[i]) v = v * 2 + m_q[i];
      m_out = (m_q.size() == int'(PAT_W)) && (v == int'(m_pat));
      if (m_out) begin
        m_cnt++;
        if (!o) m_q.delete();
      end
    end
  endtask

  initial begin
    // Reset, overlap=0, 101010
    vecs.push_back(mk(1,1,0,0,0,'0, 0,0,0,"t1_rst"));
    vecs.push_back(mk(0,1,1,0,0,'0, 0,1,0,"t1_b1"));
    vecs.push_back(mk(0,1,0,0,0,'0, 0,2,0,"t1_b2"));
    vecs.push_back(mk(0,1,1,0,0,'0, 0,3,0,"t1_b3"));
    vecs.push_back(mk(0,1,0,0,0,'0, 1,0,1,"t1_b4"));
    vecs.push_back(mk(0,1,1,0,0,'0, 0,1,1,"t1_b5"));
    vecs.push_back(mk(0,1,0,0,0,'0, 0,2,1,"t1_b6"));
    // Reset, overlap=1, 101010
    vecs.push_back(mk(1,0,0,1,0,'0, 0,0,0,"t2_rst"));
    vecs.push_back(mk(0,1,1,1,0,'0, 0,1,0,"t2_b1"));
    vecs.push_back(mk(0,1,0,1,0,'0, 0,2,0,"t2_b2"));
    vecs.push_back(mk(0,1,1,1,0,'0, 0,3,0,"t2_b3"));
    vecs.push_back(mk(0,1,0,1,0,'0, 1,4,1,"t2_b4"));
    vecs.push_back(mk(0,1,1,1,0,'0, 0,4,1,"t2_b5"));
    vecs.push_back(mk(0,1,0,1,0,'0, 1,4,2,"t2_b6"));
    // Reset, overlap=0, 10101010
    vecs.push_back(mk(1,0,0,0,0,'0, 0,0,0,"t3_rst"));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0,1,logic'(~i[0]),0,0,'0, logic'(i==3 || i==7),
                        (i < 4) ? ((i==3) ? 0 : i+1) : ((i==7) ? 0 : i-3),
                        (i < 3) ? 0 : ((i < 7) ? 1 : 2), "t3_bit"));
    // Enable gap holds state
    vecs.push_back(mk(1,0,0,0,0,'0, 0,0,0,"t4_rst"));
    vecs.push_back(mk(0,1,1,0,0,'0, 0,1,0,"t4_b1"));
    vecs.push_back(mk(0,1,0,0,0,'0, 0,2,0,"t4_b2"));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0,0,logic'(i[0]),0,0,'0, 0,2,0,"t4_gap"));
    vecs.push_back(mk(0,1,1,0,0,'0, 0,3,0,"t4_b3"));
    vecs.push_back(mk(0,1,0,0,0,'0, 1,0,1,"t4_b4"));
    // Pattern load discards the bit on its edge
    vecs.push_back(mk(1,0,0,0,0,'0, 0,0,0,"t5_rst"));
    vecs.push_back(mk(0,1,1,0,0,'0, 0,1,0,"t5_b1"));
    vecs.push_back(mk(0,1,1,0,0,'0, 0,2,0,"t5_b2"));
    vecs.push_back(mk(0,1,1,0,1,4'b1101, 0,0,0,"t5_load"));
    vecs.push_back(mk(0,1,1,0,0,'0, 0,1,0,"t5_p1"));
    vecs.push_back(mk(0,1,1,0,0,'0, 0,2,0,"t5_p2"));
    vecs.push_back(mk(0,1,0,0,0,'0, 0,3,0,"t5_p3"));
    vecs.push_back(mk(0,1,1,0,0,'0, 1,0,1,"t5_p4"));
    vecs.push_back(mk(0,1,1,0,0,'0, 0,1,1,"t5_q1"));
    vecs.push_back(mk(0,1,0,0,0,'0, 0,2,1,"t5_q2"));
    vecs.push_back(mk(0,1,1,0,0,'0, 0,3,1,"t5_q3"));
    vecs.push_back(mk(0,1,0,0,0,'0, 0,4,1,"t5_q4"));
    // Reset mid-pattern; reset outranks a simultaneous load
    vecs.push_back(mk(1,0,0,0,0,'0, 0,0,0,"t6_rst"));
    vecs.push_back(mk(0,1,1,0,0,'0, 0,1,0,"t6_b1"));
    vecs.push_back(mk(0,1,0,0,0,'0, 0,2,0,"t6_b2"));
    vecs.push_back(mk(0,1,1,0,0,'0, 0,3,0,"t6_b3"));
    vecs.push_back(mk(1,1,0,0,1,4'b0000, 0,0,0,"t6_rst_mid"));
    vecs.push_back(mk(0,1,0,0,0,'0, 0,1,0,"t6_lone0"));
    vecs.push_back(mk(1,0,0,0,0,'0, 0,0,0,"t6_rst2"));
    vecs.push_back(mk(0,1,1,0,0,'0, 0,1,0,"t6_c1"));
    vecs.push_back(mk(0,1,0,0,0,'0, 0,2,0,"t6_c2"));
    vecs.push_back(mk(0,1,1,0,0,'0, 0,3,0,"t6_c3"));
    vecs.push_back(mk(0,1,0,0,0,'0, 1,0,1,"t6_c4"));

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].en, vecs[i].din, vecs[i].ov, vecs[i].ld, vecs[i].pin);
      chk({vecs[i].tag, "_out"},  int'(out),       int'(vecs[i].e_out));
      chk({vecs[i].tag, "_fill"}, int'(fill),      vecs[i].e_fill);
      chk({vecs[i].tag, "_cnt"},  int'(match_cnt), vecs[i].e_cnt);
    end

    // Saturation: all-zero pattern in overlap mode, 2-bit counter
    s_rst = 1'b1; s_en = 1'b1; s_din = 1'b0; s_ov = 1'b1;
    @(posedge clk); #1;
    chk("sat_rst_cnt", int'(s_cnt), 0);
    s_rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      chk("sat_out",  int'(s_out),  (k >= 4) ? 1 : 0);
      chk("sat_fill", int'(s_fill), (k < 4) ? k : 4);
      chk("sat_cnt",  int'(s_cnt),  (k < 4) ? 0 : ((k - 3 > 3) ? 3 : k - 3));
    end
    s_en = 1'b0;

    // Randomized traffic against the reference model
    model_step(1, 0, 0, 0, 0, '0);
    apply(1, 0, 0, 0, 0, '0);
    for (int n = 0; n < 1500; n++) begin
      logic r, e, d, o, l;
      logic [PAT_W-1:0] p;
      r = ($urandom_range(0, 99) < 2);
      l = ($urandom_range(0, 99) < 3);
      e = ($urandom_range(0, 99) < 75);
      d = 1'($urandom);
      o = ((n / 50) % 2 == 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
      p = PAT_W'($urandom);
      model_step(r, e, d, o, l, p);
      apply(r, e, d, o, l, p);
      chk("rnd_out",  int'(out),       int'(m_out));
      chk("rnd_fill", int'(fill),      m_q.size());
      chk("rnd_cnt",  int'(match_cnt), (m_cnt > 255) ? 255 : m_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
